// File: rtl/recip_interp_pipe.sv
// recip_interp_pipe: three-stage reciprocal-seed evaluator.
// Computes result = base - fd*dx + sd*dx^2 from a run-time loadable
// coefficient table, with valid/ready handshakes on both sides.
// Optional build macro: RECIP_INTERP_SAT_STATUS_EN adds out_sat and sat_cnt.
module recip_interp_pipe #(
  parameter int IDX_W  = 7,
  parameter int DX_W   = 12,
  parameter int BASE_W = 27,
  parameter int FD_W   = 18,
  parameter int SD_W   = 11,
  parameter int OUT_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_we,
  input  logic [IDX_W-1:0]      tbl_addr,
  input  logic [BASE_W-1:0]     tbl_base,
  input  logic [FD_W-1:0]       tbl_fd,
  input  logic [SD_W-1:0]       tbl_sd,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W+DX_W-1:0] in_opnd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_res
`ifdef RECIP_INTERP_SAT_STATUS_EN
  ,
  output logic                  out_sat,
  output logic [15:0]           sat_cnt
`endif
);

  localparam int DEPTH = 2**IDX_W;
  localparam int OP_W  = IDX_W + DX_W;
  localparam int ACC_W = BASE_W + 2;

  // Coefficient table (not reset; survives rst)
  logic [BASE_W-1:0] tab_base [DEPTH];
  logic [FD_W-1:0]   tab_fd   [DEPTH];
  logic [SD_W-1:0]   tab_sd   [DEPTH];

  // Global enable: every stage moves only when the output slot can drain
  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Table write port, independent of pipeline stalls
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tab_base[tbl_addr] <= tbl_base;
      tab_fd[tbl_addr]   <= tbl_fd;
      tab_sd[tbl_addr]   <= tbl_sd;
    end
  end

  // ---------------- Stage 1: table read, dx capture ----------------
  logic              s1_valid;
  logic [BASE_W-1:0] s1_base;
  logic [FD_W-1:0]   s1_fd;
  logic [SD_W-1:0]   s1_sd;
  logic [DX_W-1:0]   s1_dx;

  // Stage 1 valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
    end
  end

  // Stage 1 data; a same-edge table write is not yet visible, so the old entry is read
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_base <= tab_base[in_opnd[OP_W-1:DX_W]];
      s1_fd   <= tab_fd[in_opnd[OP_W-1:DX_W]];
      s1_sd   <= tab_sd[in_opnd[OP_W-1:DX_W]];
      s1_dx   <= in_opnd[DX_W-1:0];
    end
  end

  // ---------------- Stage 2: products ----------------
  logic [FD_W+DX_W-1:0] fd_prod;
  logic [2*DX_W-1:0]    dx_sq;
  logic [SD_W+DX_W-1:0] sd_prod;

  // Full-width products; the upper halves are the >>DX_W terms
  always_comb begin
    fd_prod = {{DX_W{1'b0}}, s1_fd} * {{FD_W{1'b0}}, s1_dx};
    dx_sq   = {{DX_W{1'b0}}, s1_dx} * {{DX_W{1'b0}}, s1_dx};
    sd_prod = {{DX_W{1'b0}}, s1_sd} * {{SD_W{1'b0}}, dx_sq[2*DX_W-1:DX_W]};
  end

  logic unused_prod_lo;
  assign unused_prod_lo = ^{fd_prod[DX_W-1:0], dx_sq[DX_W-1:0], sd_prod[DX_W-1:0]};

  logic              s2_valid;
  logic [BASE_W-1:0] s2_base;
  logic [FD_W-1:0]   s2_t1;
  logic [SD_W-1:0]   s2_t2;

  // Stage 2 valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 data
  always_ff @(posedge clk) begin
    if (adv && s1_valid) begin
      s2_base <= s1_base;
      s2_t1   <= fd_prod[FD_W+DX_W-1:DX_W];
      s2_t2   <= sd_prod[SD_W+DX_W-1:DX_W];
    end
  end

  // ---------------- Stage 3: accumulate, clamp, truncate ----------------
  logic signed [ACC_W-1:0] acc;
  logic [BASE_W-1:0]       clamped;
  logic                    clamp_hit;

  // Two extra bits hold the sign and the overflow above 2**BASE_W-1
  always_comb begin
    acc = $signed({2'b00, s2_base})
        - $signed({{(ACC_W-FD_W){1'b0}}, s2_t1})
        + $signed({{(ACC_W-SD_W){1'b0}}, s2_t2});
    clamped   = acc[BASE_W-1:0];
    clamp_hit = 1'b0;
    if (acc[ACC_W-1]) begin
      clamped   = '0;
      clamp_hit = 1'b1;
    end else if (acc[BASE_W]) begin
      clamped   = '1;
      clamp_hit = 1'b1;
    end
  end

  generate
    if (BASE_W > OUT_W) begin : g_trunc
      logic unused_trunc;
      assign unused_trunc = ^clamped[BASE_W-OUT_W-1:0];
    end
  endgenerate

  // Output stage valid and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_res <= clamped[BASE_W-1 -: OUT_W];
      end
    end
  end

`ifdef RECIP_INTERP_SAT_STATUS_EN
  // Clamp flag travels with its result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (adv && s2_valid) begin
      out_sat <= clamp_hit;
    end
  end

  // Saturating count of consumed clamped results
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_clamp_hit;
  assign unused_clamp_hit = clamp_hit;
`endif

endmodule

// File: tb/tb_recip_interp_pipe.sv
// Self-checking bench for recip_interp_pipe (scoreboard + per-scenario tasks).
// Build with RECIP_INTERP_SAT_STATUS_EN defined to also check out_sat/sat_cnt.
module tb_recip_interp_pipe;

  localparam int IDX_W  = 7;
  localparam int DX_W   = 12;
  localparam int BASE_W = 27;
  localparam int FD_W   = 18;
  localparam int SD_W   = 11;
  localparam int OUT_W  = 24;
  localparam int OP_W   = IDX_W + DX_W;

  logic              clk;
  logic              rst;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_addr;
  logic [BASE_W-1:0] tbl_base;
  logic [FD_W-1:0]   tbl_fd;
  logic [SD_W-1:0]   tbl_sd;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opnd;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_res;
`ifdef RECIP_INTERP_SAT_STATUS_EN
  logic              out_sat;
  logic [15:0]       sat_cnt;
  logic [15:0]       sat_mdl;
`endif

  recip_interp_pipe #(
    .IDX_W(IDX_W), .DX_W(DX_W), .BASE_W(BASE_W),
    .FD_W(FD_W), .SD_W(SD_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_base(tbl_base),
    .tbl_fd(tbl_fd), .tbl_sd(tbl_sd),
    .in_valid(in_valid), .in_ready(in_ready), .in_opnd(in_opnd),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res)
`ifdef RECIP_INTERP_SAT_STATUS_EN
    , .out_sat(out_sat), .sat_cnt(sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference copy of the coefficient table
  logic [BASE_W-1:0] m_base [0:(1<<IDX_W)-1];
  logic [FD_W-1:0]   m_fd   [0:(1<<IDX_W)-1];
  logic [SD_W-1:0]   m_sd   [0:(1<<IDX_W)-1];

  logic [OUT_W-1:0] exp_res_q [$];
  bit               exp_sat_q [$];

  always @(posedge clk) begin
    if (tbl_we) begin
      m_base[tbl_addr] <= tbl_base;
      m_fd[tbl_addr]   <= tbl_fd;
      m_sd[tbl_addr]   <= tbl_sd;
    end
  end

  function automatic void model(input logic [OP_W-1:0] op,
                                output logic [OUT_W-1:0] r, output bit s);
    logic [IDX_W-1:0] idx;
    longint b, f, d, x, t1, sq, t2, acc, maxv;
    idx  = op[OP_W-1:DX_W];
    x    = longint'(op[DX_W-1:0]);
    b    = longint'(m_base[idx]);
    f    = longint'(m_fd[idx]);
    d    = longint'(m_sd[idx]);
    t1   = (f * x) / (longint'(1) << DX_W);
    sq   = (x * x) / (longint'(1) << DX_W);
    t2   = (d * sq) / (longint'(1) << DX_W);
    acc  = b - t1 + t2;
    maxv = (longint'(1) << BASE_W) - 1;
    s = 1'b0;
    if (acc < 0) begin
      acc = 0;
      s = 1'b1;
    end else if (acc > maxv) begin
      acc = maxv;
      s = 1'b1;
    end
    r = OUT_W'(acc / (longint'(1) << (BASE_W - OUT_W)));
  endfunction

  // Scoreboard: push on accept, pop and compare on consume
  always @(negedge clk) begin
    logic [OUT_W-1:0] er;
    bit               es;
    if (rst) begin
      exp_res_q.delete();
      exp_sat_q.delete();
`ifdef RECIP_INTERP_SAT_STATUS_EN
      sat_mdl = '0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got out_res=%h, required no output", out_res);
        end else begin
          er = exp_res_q.pop_front();
          es = exp_sat_q.pop_front();
          if (out_res !== er) begin
            errors++;
            $display("FAIL sb_res: got %h, required %h", out_res, er);
          end
`ifdef RECIP_INTERP_SAT_STATUS_EN
          checks++;
          if (out_sat !== es) begin
            errors++;
            $display("FAIL sb_sat: got %b, required %b", out_sat, es);
          end
          if (es && sat_mdl != 16'hffff) sat_mdl = sat_mdl + 16'd1;
`endif
        end
      end
      if (in_valid && in_ready) begin
        model(in_opnd, er, es);
        exp_res_q.push_back(er);
        exp_sat_q.push_back(es);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [IDX_W-1:0] a, input logic [BASE_W-1:0] b,
                             input logic [FD_W-1:0] f, input logic [SD_W-1:0] s);
    tbl_we = 1'b1; tbl_addr = a; tbl_base = b; tbl_fd = f; tbl_sd = s;
    step();
    tbl_we = 1'b0;
  endtask

  // Presents an operand and returns just after the edge that accepted it
  task automatic send(input logic [OP_W-1:0] op);
    int n;
    in_valid = 1'b1;
    in_opnd  = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Returns on a falling edge where out_valid is high
  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_out_timeout: got out_valid=0, required 1");
    end
  endtask

  task automatic drain();
    bit done;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_res_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d pending results, required 0", exp_res_q.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tbl_we = 1'b0;
    tbl_addr = '0; tbl_base = '0; tbl_fd = '0; tbl_sd = '0; in_opnd = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (out_res !== 24'h0) begin errors++; $display("FAIL reset_out_res: got %h, required 000000", out_res); end
`ifdef RECIP_INTERP_SAT_STATUS_EN
    checks++;
    if (sat_cnt !== 16'h0) begin errors++; $display("FAIL reset_sat_cnt: got %h, required 0000", sat_cnt); end
`endif
    step();
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    write_entry(7'd0, 27'h3fffffe, 18'h3fff7, 11'h7e8);
    send({7'd0, 12'h000});
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL latency: got %0d cycles, required 3", n); end
    checks++;
    if (out_res !== 24'h7fffff) begin errors++; $display("FAIL basic_dx0: got %h, required 7fffff", out_res); end
`ifdef RECIP_INTERP_SAT_STATUS_EN
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b, required 0", out_sat); end
`endif
    step();
    send({7'd0, 12'h800});
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'h7fc03f) begin errors++; $display("FAIL basic_dx800: got %h, required 7fc03f", out_res); end
    end
    step();
  endtask

  task automatic test_clamp();
    bit ok;
    write_entry(7'd1, 27'h0, 18'h3ffff, 11'h0);
    write_entry(7'd2, 27'h7ffffff, 18'h0, 11'h7ff);
    send({7'd1, 12'hfff});
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'h000000) begin errors++; $display("FAIL clamp_neg: got %h, required 000000", out_res); end
`ifdef RECIP_INTERP_SAT_STATUS_EN
      checks++;
      if (out_sat !== 1'b1) begin errors++; $display("FAIL clamp_neg_sat: got %b, required 1", out_sat); end
`endif
    end
    step();
    send({7'd2, 12'hfff});
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'hffffff) begin errors++; $display("FAIL clamp_pos: got %h, required ffffff", out_res); end
`ifdef RECIP_INTERP_SAT_STATUS_EN
      checks++;
      if (out_sat !== 1'b1) begin errors++; $display("FAIL clamp_pos_sat: got %b, required 1", out_sat); end
`endif
    end
    step();
`ifdef RECIP_INTERP_SAT_STATUS_EN
    checks++;
    if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt_after_clamp: got %0d, required 2", sat_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit done;
    write_entry(7'd3, 27'h1234567, 18'h2abcd, 11'h155);
    write_entry(7'd4, 27'h5555555, 18'h01234, 11'h6aa);
    out_ready = 1'b0;
    fork
      begin
        send({7'd3, 12'h123});
        send({7'd4, 12'h456});
        send({7'd3, 12'habc});
        send({7'd4, 12'hfed});
        in_valid = 1'b0;
      end
      begin
        wait_out(ok);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_%0d: got in_ready=%b out_valid=%b, required 0/1", i, in_ready, out_valid);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random operands against a random out_ready pattern
    for (int a = 8; a < 16; a++) begin
      write_entry(IDX_W'(a), BASE_W'($urandom), FD_W'($urandom), SD_W'($urandom));
    end
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send({IDX_W'($urandom_range(8, 15)), DX_W'($urandom)});
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
          end
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          step();
        end
      end
    join
    drain();
  endtask

  task automatic test_collision_reset();
    bit ok;
    int seen;
    write_entry(7'd5, 27'h1000000, 18'h0, 11'h0);
    tbl_we = 1'b1; tbl_addr = 7'd5; tbl_base = 27'h2000000; tbl_fd = '0; tbl_sd = '0;
    send({7'd5, 12'h000});
    tbl_we = 1'b0;
    send({7'd5, 12'h000});
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'h200000) begin errors++; $display("FAIL collide_old: got %h, required 200000", out_res); end
    end
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'h400000) begin errors++; $display("FAIL collide_new: got %h, required 400000", out_res); end
    end
    step();

    send({7'd5, 12'h100});
    send({7'd5, 12'h200});
    send({7'd5, 12'h300});
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL stale_results: got %0d, required 0", seen); end
    step();
`ifdef RECIP_INTERP_SAT_STATUS_EN
    checks++;
    if (sat_cnt !== 16'd0) begin errors++; $display("FAIL midreset_sat_cnt: got %0d, required 0", sat_cnt); end
`endif
    send({7'd5, 12'h000});
    in_valid = 1'b0;
    wait_out(ok);
    if (ok) begin
      checks++;
      if (out_res !== 24'h400000) begin errors++; $display("FAIL table_retained: got %h, required 400000", out_res); end
    end
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_collision_reset();
`ifdef RECIP_INTERP_SAT_STATUS_EN
    checks++;
    if (sat_cnt !== sat_mdl) begin errors++; $display("FAIL sat_cnt_final: got %0d, required %0d", sat_cnt, sat_mdl); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
